svm_dot_engine: RTL and testbench

Downstream consumer of the deskew stage. Once the deskew block has written the deskewed 784-pixel image to BRAM words 784..1567, this block reads it back and computes one signed dot product per support vector (SV). It takes pixels from the image BRAM and SV coefficients from a separate SV memory, and emits one result per SV over a valid/ready handshake. The SVM kernel/decision logic consumes the results.

---
 rtl/svm_dot_engine_if.sv | 37 +++
 rtl/svm_dot_engine.sv | 173 +++++++++++++++++
 tb/tb_svm_dot_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_dot_engine_if.sv
// Signal bundle between svm_dot_engine and its image BRAM, SV memory, start control and result consumer.
// master = the dot engine side, slave = the surrounding system.
interface svm_dot_engine_if #(
   parameter int WIDTH         = 16,
   parameter int NUM_SV        = 16,
   parameter int SV_ADDR_WIDTH = 14,
   parameter int RES_WIDTH     = 2*WIDTH+10
);
   localparam int IDX_WIDTH  = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
   localparam int ADDR_WIDTH = 11;

   logic                     start;
   logic                     ready;
   logic                     done_interrupt;
   logic [ADDR_WIDTH-1:0]    address;
   logic                     en;
   logic [WIDTH-1:0]         in_data;
   logic [SV_ADDR_WIDTH-1:0] sv_address;
   logic                     sv_en;
   logic [WIDTH-1:0]         sv_in_data;
   logic [RES_WIDTH-1:0]     res_data;
   logic [IDX_WIDTH-1:0]     res_idx;
   logic                     res_valid;
   logic                     res_ready;

   modport master (
      input  start, in_data, sv_in_data, res_ready,
      output ready, done_interrupt, address, en, sv_address, sv_en,
             res_data, res_idx, res_valid
   );

   modport slave (
      output start, in_data, sv_in_data, res_ready,
      input  ready, done_interrupt, address, en, sv_address, sv_en,
             res_data, res_idx, res_valid
   );
endinterface

// File: rtl/svm_dot_engine.sv
// Streams the deskewed image against each support vector and emits one signed dot product per SV.
// Optional macro DOT_SAT_OUT_EN: results are rescaled to Q2.14 and saturated to WIDTH bits.
module svm_dot_engine #(
   parameter int WIDTH         = 16,
   parameter int IMG_LEN       = 784,
   parameter int IMG_BASE      = 784,
   parameter int NUM_SV        = 16,
   parameter int SV_ADDR_WIDTH = 14,
   parameter int RES_WIDTH     = 2*WIDTH+10
)(
   input  logic               clk,
   input  logic               reset,
   svm_dot_engine_if.master   dot_io
);
   localparam int IDX_WIDTH  = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
   localparam int K_WIDTH    = $clog2(IMG_LEN);
   localparam int PROD_WIDTH = 2*WIDTH;
   localparam int ADDR_WIDTH = 11;

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, DONE} state_t;

   state_t                      state_q, state_d;
   logic [K_WIDTH-1:0]          kCnt_q, kCnt_d;
   logic [IDX_WIDTH-1:0]        svCnt_q, svCnt_d;
   logic [SV_ADDR_WIDTH-1:0]    svBase_q, svBase_d;
   logic [1:0]                  drainCnt_q, drainCnt_d;

   logic                        rdValid_q, capValid_q, prodValid_q;
   logic signed [WIDTH-1:0]     pix_q, coef_q;
   logic signed [PROD_WIDTH-1:0] prod_q;
   logic signed [RES_WIDTH-1:0] acc_q;
   logic signed [RES_WIDTH-1:0] resValue;

   logic lastPixel, lastSv, enterMac;

   assign lastPixel = (kCnt_q == K_WIDTH'(IMG_LEN-1));
   assign lastSv    = (svCnt_q == IDX_WIDTH'(NUM_SV-1));
   assign enterMac  = (state_d == MAC) && (state_q != MAC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         kCnt_q     <= '0;
         svCnt_q    <= '0;
         svBase_q   <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         kCnt_q     <= kCnt_d;
         svCnt_q    <= svCnt_d;
         svBase_q   <= svBase_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // svBase tracks s*IMG_LEN incrementally so no multiplier sits on the address path
   always_comb begin
      state_d    = state_q;
      kCnt_d     = kCnt_q;
      svCnt_d    = svCnt_q;
      svBase_d   = svBase_q;
      drainCnt_d = drainCnt_q;
      case (state_q)
         IDLE: begin
            if (dot_io.start) begin
               state_d  = MAC;
               kCnt_d   = '0;
               svCnt_d  = '0;
               svBase_d = '0;
            end
         end
         MAC: begin
            kCnt_d = kCnt_q + K_WIDTH'(1);
            if (lastPixel) begin
               kCnt_d     = '0;
               drainCnt_d = '0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            drainCnt_d = drainCnt_q + 2'd1;
            if (drainCnt_q == 2'd2) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (dot_io.res_ready) begin
               if (lastSv) begin
                  state_d = DONE;
               end else begin
                  state_d  = MAC;
                  svCnt_d  = svCnt_q + IDX_WIDTH'(1);
                  svBase_d = svBase_q + SV_ADDR_WIDTH'(IMG_LEN);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dot_io.ready          = (state_q == IDLE);
      dot_io.done_interrupt = (state_q == DONE);
      dot_io.en             = 1'b0;
      dot_io.sv_en          = 1'b0;
      dot_io.address        = '0;
      dot_io.sv_address     = '0;
      dot_io.res_valid      = 1'b0;
      dot_io.res_data       = '0;
      dot_io.res_idx        = '0;
      if (state_q == MAC) begin
         dot_io.en         = 1'b1;
         dot_io.sv_en      = 1'b1;
         dot_io.address    = ADDR_WIDTH'(IMG_BASE) + ADDR_WIDTH'(kCnt_q);
         dot_io.sv_address = svBase_q + SV_ADDR_WIDTH'(kCnt_q);
      end
      if (state_q == OUT) begin
         dot_io.res_valid = 1'b1;
         dot_io.res_data  = resValue;
         dot_io.res_idx   = svCnt_q;
      end
   end

   // Read-data capture, multiply and accumulate; the pipeline is empty whenever MAC is entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdValid_q   <= 1'b0;
         capValid_q  <= 1'b0;
         prodValid_q <= 1'b0;
         pix_q       <= '0;
         coef_q      <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
      end else begin
         rdValid_q   <= (state_q == MAC);
         capValid_q  <= rdValid_q;
         prodValid_q <= capValid_q;
         if (rdValid_q) begin
            pix_q  <= dot_io.in_data;
            coef_q <= dot_io.sv_in_data;
         end
         if (capValid_q) begin
            prod_q <= pix_q * coef_q;
         end
         if (enterMac) begin
            acc_q <= '0;
         end else if (prodValid_q) begin
            acc_q <= acc_q + {{(RES_WIDTH-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
         end
      end
   end

`ifdef DOT_SAT_OUT_EN
   localparam logic signed [RES_WIDTH-1:0] SAT_MAX = {{(RES_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [RES_WIDTH-1:0] SAT_MIN = {{(RES_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   logic signed [RES_WIDTH-1:0] shifted;

   always_comb begin
      shifted = acc_q >>> (WIDTH-2);
      if (shifted > SAT_MAX) begin
         resValue = SAT_MAX;
      end else if (shifted < SAT_MIN) begin
         resValue = SAT_MIN;
      end else begin
         resValue = shifted;
      end
   end
`else
   assign resValue = acc_q;
`endif

endmodule

// File: tb/tb_svm_dot_engine.sv
// Self-checking bench for svm_dot_engine: memories are modelled here and every result is
// compared with a plain-arithmetic dot product (DOT_SAT_OUT_EN selects the saturated form).
module tb_svm_dot_engine;
   localparam int WIDTH     = 16;
   localparam int IMG_LEN   = 784;
   localparam int IMG_BASE  = 784;
   localparam int NUM_SV    = 3;
   localparam int SVAW      = 14;
   localparam int RES_WIDTH = 2*WIDTH+10;
   localparam int PERIOD_SV = IMG_LEN+4;

`ifdef DOT_SAT_OUT_EN
   localparam logic [RES_WIDTH-1:0] ONES_EXP   = 42'h000_0000_7FFF;
   localparam logic [RES_WIDTH-1:0] NEG_EXP    = 42'h3FF_FFFF_8000;
   localparam logic [RES_WIDTH-1:0] SINGLE_EXP = 42'h000_0000_2000;
`else
   localparam logic [RES_WIDTH-1:0] ONES_EXP   = 42'h031_0000_0000;
   localparam logic [RES_WIDTH-1:0] NEG_EXP    = 42'h3CF_0000_0000;
   localparam logic [RES_WIDTH-1:0] SINGLE_EXP = 42'h000_0800_0000;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cycleCnt = 0;
   int   checks = 0;
   int   errors = 0;

   logic [WIDTH-1:0] imgMem [0:2047];
   logic [WIDTH-1:0] svMem  [0:NUM_SV*IMG_LEN-1];

   logic [RES_WIDTH-1:0] gotData [NUM_SV];
   int   gotIdx [NUM_SV];
   int   validCyc [NUM_SV];
   int   hsCyc [NUM_SV];
   int   firstAddrCyc [NUM_SV];
   int   addrErr, enCount, doneCyc, donePulses, readyCyc, stableErr;
   logic readyAtRel1;
   bit   timedOut;

   svm_dot_engine_if #(.WIDTH(WIDTH), .NUM_SV(NUM_SV), .SV_ADDR_WIDTH(SVAW),
                       .RES_WIDTH(RES_WIDTH)) bus ();

   svm_dot_engine #(.WIDTH(WIDTH), .IMG_LEN(IMG_LEN), .IMG_BASE(IMG_BASE), .NUM_SV(NUM_SV),
                    .SV_ADDR_WIDTH(SVAW), .RES_WIDTH(RES_WIDTH)) dut (
      .clk(clk),
      .reset(reset),
      .dot_io(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // One-cycle synchronous read memories
   always @(posedge clk) begin
      if (bus.en) bus.in_data <= imgMem[bus.address];
      if (bus.sv_en) bus.sv_in_data <= svMem[bus.sv_address];
   end

   function automatic logic [RES_WIDTH-1:0] modelResult(input int s);
      longint sum = 0;
      for (int k = 0; k < IMG_LEN; k++) begin
         sum += longint'($signed(imgMem[IMG_BASE+k])) * longint'($signed(svMem[s*IMG_LEN+k]));
      end
`ifdef DOT_SAT_OUT_EN
      sum = sum >>> (WIDTH-2);
      if (sum > 32767) sum = 32767;
      else if (sum < -32768) sum = -32768;
`endif
      return RES_WIDTH'(sum);
   endfunction

   task automatic fillConst(input logic [WIDTH-1:0] pix, input logic [WIDTH-1:0] coef);
      for (int k = 0; k < IMG_LEN; k++) imgMem[IMG_BASE+k] = pix;
      for (int i = 0; i < NUM_SV*IMG_LEN; i++) svMem[i] = coef;
   endtask

   task automatic fillRandom();
      for (int k = 0; k < IMG_LEN; k++) imgMem[IMG_BASE+k] = WIDTH'($urandom);
      for (int i = 0; i < NUM_SV*IMG_LEN; i++) svMem[i] = WIDTH'($urandom);
   endtask

   // Drives one run and records what the DUT shows; the test tasks do the judging
   task automatic captureRun(input int holdCycles, input bit busyPulse);
      int rel, sv, k, holdLeft, startCyc, limit;
      bit seen;
      addrErr = 0; enCount = 0; doneCyc = -1; donePulses = 0; readyCyc = -1;
      stableErr = 0; timedOut = 0; readyAtRel1 = 1'b1;
      for (int i = 0; i < NUM_SV; i++) begin
         gotData[i] = '0; gotIdx[i] = -1; validCyc[i] = -1; hsCyc[i] = -1; firstAddrCyc[i] = -1;
      end
      sv = 0; k = 0; seen = 0; holdLeft = holdCycles;
      limit = NUM_SV*(PERIOD_SV+holdCycles+2)+50;
      @(negedge clk);
      bus.start = 1'b1;
      bus.res_ready = 1'b1;
      startCyc = cycleCnt;
      forever begin
         @(negedge clk);
         rel = cycleCnt - startCyc;
         bus.start = busyPulse && (rel == 100);
         if (rel == 1) readyAtRel1 = bus.ready;
         if (bus.en) begin
            if (sv < NUM_SV) begin
               if (k == 0) firstAddrCyc[sv] = rel;
               if (bus.address !== 11'(IMG_BASE+k) || bus.sv_address !== SVAW'(sv*IMG_LEN+k)) addrErr++;
            end else begin
               addrErr++;
            end
            k++;
            enCount++;
         end
         if (bus.done_interrupt) begin
            donePulses++;
            doneCyc = rel;
         end
         if (bus.res_valid && sv < NUM_SV) begin
            if (bus.en || bus.sv_en || bus.address !== '0 || bus.sv_address !== '0) stableErr++;
            if (!seen) begin
               seen = 1;
               validCyc[sv] = rel;
               gotData[sv] = bus.res_data;
               gotIdx[sv] = int'(bus.res_idx);
            end else if (bus.res_data !== gotData[sv] || int'(bus.res_idx) != gotIdx[sv]) begin
               stableErr++;
            end
            if (holdLeft > 0) begin
               bus.res_ready = 1'b0;
               holdLeft--;
            end else begin
               bus.res_ready = 1'b1;
               hsCyc[sv] = rel;
               sv++;
               k = 0;
               seen = 0;
               holdLeft = holdCycles;
            end
         end else begin
            bus.res_ready = 1'b1;
         end
         if (sv == NUM_SV && bus.ready) begin
            readyCyc = rel;
            break;
         end
         if (rel > limit) begin
            timedOut = 1;
            break;
         end
      end
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.done_interrupt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: ready/valid/done=%b%b%b, expected 100", bus.ready, bus.res_valid, bus.done_interrupt);
      end
      checks++;
      if (bus.address !== '0 || bus.sv_address !== '0 || bus.en !== 1'b0 || bus.sv_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mem: address=%h sv_address=%h en=%b sv_en=%b, expected all 0", bus.address, bus.sv_address, bus.en, bus.sv_en);
      end
      checks++;
      if (bus.res_data !== '0 || bus.res_idx !== '0) begin
         errors++;
         $display("[TB] FAIL reset_res: res_data=%h res_idx=%0d, expected 0/0", bus.res_data, bus.res_idx);
      end
   endtask

   task automatic test_basic();
      fillConst(16'h4000, 16'h4000);
      captureRun(0, 0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout: run did not complete, expected completion"); end
      for (int s = 0; s < NUM_SV; s++) begin
         checks++;
         if (gotData[s] !== ONES_EXP) begin
            errors++;
            $display("[TB] FAIL basic_data[%0d]: got %h, expected %h", s, gotData[s], ONES_EXP);
         end
         checks++;
         if (gotIdx[s] != s) begin
            errors++;
            $display("[TB] FAIL basic_idx[%0d]: got %0d, expected %0d", s, gotIdx[s], s);
         end
      end
      checks++;
      if (readyAtRel1 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop: ready=%b in cycle 1, expected 0", readyAtRel1); end
      checks++;
      if (validCyc[0] != PERIOD_SV) begin errors++; $display("[TB] FAIL basic_latency: res_valid in cycle %0d, expected %0d", validCyc[0], PERIOD_SV); end
      for (int s = 1; s < NUM_SV; s++) begin
         checks++;
         if (validCyc[s] - validCyc[s-1] != PERIOD_SV) begin
            errors++;
            $display("[TB] FAIL basic_spacing[%0d]: got %0d cycles, expected %0d", s, validCyc[s]-validCyc[s-1], PERIOD_SV);
         end
      end
      checks++;
      if (enCount != NUM_SV*IMG_LEN) begin errors++; $display("[TB] FAIL basic_en_count: got %0d, expected %0d", enCount, NUM_SV*IMG_LEN); end
   endtask

   task automatic test_negative();
      fillConst(16'hC000, 16'h4000);
      captureRun(0, 0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL neg_timeout: run did not complete, expected completion"); end
      for (int s = 0; s < NUM_SV; s++) begin
         checks++;
         if (gotData[s] !== NEG_EXP) begin
            errors++;
            $display("[TB] FAIL neg_data[%0d]: got %h, expected %h", s, gotData[s], NEG_EXP);
         end
      end
   endtask

   task automatic test_single_term();
      fillConst(16'h0000, 16'h0000);
      imgMem[IMG_BASE+5] = 16'h4000;
      svMem[5] = 16'h2000;
      captureRun(0, 0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL single_timeout: run did not complete, expected completion"); end
      checks++;
      if (gotData[0] !== SINGLE_EXP) begin errors++; $display("[TB] FAIL single_data[0]: got %h, expected %h", gotData[0], SINGLE_EXP); end
      for (int s = 1; s < NUM_SV; s++) begin
         checks++;
         if (gotData[s] !== '0) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h, expected 0", s, gotData[s]); end
      end
      checks++;
      if (addrErr != 0) begin errors++; $display("[TB] FAIL single_addr_seq: %0d wrong addresses, expected 0", addrErr); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 2; r++) begin
         fillRandom();
         captureRun(0, 0);
         checks++;
         if (timedOut) begin errors++; $display("[TB] FAIL rand_timeout: run did not complete, expected completion"); end
         for (int s = 0; s < NUM_SV; s++) begin
            checks++;
            if (gotData[s] !== modelResult(s)) begin
               errors++;
               $display("[TB] FAIL rand_data[%0d]: got %h, expected %h", s, gotData[s], modelResult(s));
            end
         end
         checks++;
         if (addrErr != 0) begin errors++; $display("[TB] FAIL rand_addr_seq: %0d wrong addresses, expected 0", addrErr); end
      end
   endtask

   task automatic test_backpressure();
      fillRandom();
      captureRun(10, 0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL bp_timeout: run did not complete, expected completion"); end
      checks++;
      if (stableErr != 0) begin errors++; $display("[TB] FAIL bp_stable: %0d unstable/active cycles, expected 0", stableErr); end
      for (int s = 0; s < NUM_SV; s++) begin
         checks++;
         if (gotData[s] !== modelResult(s) || gotIdx[s] != s) begin
            errors++;
            $display("[TB] FAIL bp_data[%0d]: got %h idx %0d, expected %h idx %0d", s, gotData[s], gotIdx[s], modelResult(s), s);
         end
      end
      for (int s = 0; s < NUM_SV-1; s++) begin
         checks++;
         if (firstAddrCyc[s+1] != hsCyc[s] + 1) begin
            errors++;
            $display("[TB] FAIL bp_restart[%0d]: first address in cycle %0d, expected %0d", s+1, firstAddrCyc[s+1], hsCyc[s]+1);
         end
      end
   endtask

   task automatic test_busy_start();
      int idleBad = 0;
      fillRandom();
      captureRun(0, 1);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL busy_timeout: run did not complete, expected completion"); end
      checks++;
      if (doneCyc != NUM_SV*PERIOD_SV+1) begin errors++; $display("[TB] FAIL busy_done_cycle: got %0d, expected %0d", doneCyc, NUM_SV*PERIOD_SV+1); end
      checks++;
      if (donePulses != 1) begin errors++; $display("[TB] FAIL busy_done_pulses: got %0d, expected 1", donePulses); end
      checks++;
      if (readyCyc != NUM_SV*PERIOD_SV+2) begin errors++; $display("[TB] FAIL busy_ready_cycle: got %0d, expected %0d", readyCyc, NUM_SV*PERIOD_SV+2); end
      checks++;
      if (enCount != NUM_SV*IMG_LEN) begin errors++; $display("[TB] FAIL busy_en_count: got %0d, expected %0d", enCount, NUM_SV*IMG_LEN); end
      checks++;
      if (gotData[NUM_SV-1] !== modelResult(NUM_SV-1)) begin
         errors++;
         $display("[TB] FAIL busy_data: got %h, expected %h", gotData[NUM_SV-1], modelResult(NUM_SV-1));
      end
      repeat (20) begin
         @(negedge clk);
         if (bus.en || !bus.ready) idleBad++;
      end
      checks++;
      if (idleBad != 0) begin errors++; $display("[TB] FAIL busy_idle_after: %0d active cycles, expected 0", idleBad); end
   endtask

   task automatic test_midrun_reset();
      fillRandom();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (PERIOD_SV + 110) @(negedge clk);
      checks++;
      if (bus.en !== 1'b1 || bus.res_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_in_mac: en=%b res_valid=%b, expected 1/0", bus.en, bus.res_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.ready !== 1'b1 || bus.en !== 1'b0 || bus.sv_en !== 1'b0 || bus.res_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_ctrl: ready=%b en=%b sv_en=%b valid=%b, expected 1000", bus.ready, bus.en, bus.sv_en, bus.res_valid);
      end
      checks++;
      if (bus.address !== '0 || bus.sv_address !== '0 || bus.res_data !== '0 || bus.res_idx !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_bus: address=%h sv_address=%h res_data=%h, expected 0", bus.address, bus.sv_address, bus.res_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      captureRun(0, 0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL mid_timeout: run did not complete, expected completion"); end
      checks++;
      if (gotData[0] !== modelResult(0) || gotIdx[0] != 0) begin
         errors++;
         $display("[TB] FAIL mid_after_data: got %h idx %0d, expected %h idx 0", gotData[0], gotIdx[0], modelResult(0));
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 2048; i++) imgMem[i] = WIDTH'($urandom);
      for (int i = 0; i < NUM_SV*IMG_LEN; i++) svMem[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] basic run");
      test_basic();
      $display("[TB] negative pixels");
      test_negative();
      $display("[TB] single nonzero term");
      test_single_term();
      $display("[TB] randomized runs");
      test_random();
      $display("[TB] backpressure");
      test_backpressure();
      $display("[TB] busy start and done timing");
      test_busy_start();
      $display("[TB] mid-run reset");
      test_midrun_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
